// File: rtl/fornecedor_de_comandos.sv
// Command supplier for the falling-pattern lanes: round-robin arbitration of
// per-lane trocar requests, one-hot LFSR commands, and song-length accounting.
module fornecedor_de_comandos #(
  parameter int         N_LANES  = 3,
  parameter int         LIST_LEN = 10,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic                   CLOCK_25,
  input  logic                   reset,
  input  logic [N_LANES-1:0]     trocar,
  output logic [4*N_LANES-1:0]   comando,
  output logic [N_LANES-1:0]     comando_valido,
  output logic [7:0]             restantes,
  output logic                   fim_de_jogo
);

  localparam int               PTR_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [7:0]       SEED_NZ  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_LANES - 1);

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [3:0] cmd_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  logic [N_LANES-1:0] trocar_prev;
  logic [N_LANES-1:0] pending;
  logic [N_LANES-1:0] rise;
  logic [N_LANES-1:0] grant;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   idx;
  logic               gnt_any;
  logic [7:0]         lfsr;

  // Stage 0: edge detect and round-robin search starting just after the last winner
  always_comb begin
    rise    = trocar & ~trocar_prev;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_LANES);
      if (!gnt_any && pending[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Stage 1: registered issue; once the list is exhausted grants load an empty command
  always_ff @(posedge CLOCK_25) begin
    if (!reset) begin
      trocar_prev    <= '1;
      pending        <= '0;
      ptr            <= PTR_INIT;
      lfsr           <= SEED_NZ;
      comando        <= '0;
      comando_valido <= '0;
      restantes      <= 8'(LIST_LEN);
      fim_de_jogo    <= 1'b0;
    end else begin
      trocar_prev    <= trocar;
      pending        <= (pending & ~grant) | rise;
      comando_valido <= grant;
      if (gnt_any) begin
        ptr <= gnt_idx;
        if (restantes != 8'd0) begin
          comando[4*int'(gnt_idx) +: 4] <= cmd_onehot(lfsr[1:0]);
          lfsr                          <= lfsr_step(lfsr);
          restantes                     <= restantes - 8'd1;
          if (restantes == 8'd1) begin
            fim_de_jogo <= 1'b1;
          end
        end else begin
          comando[4*int'(gnt_idx) +: 4] <= 4'b0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_fornecedor_de_comandos.sv
// Directed bench for fornecedor_de_comandos: a reference model fills a
// scoreboard as requests are driven; every valid strobe pops and compares.
module tb_fornecedor_de_comandos;

  localparam int N  = 3;
  localparam int LL = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   trocar;
  logic [4*N-1:0] comando;
  logic [N-1:0]   comando_valido;
  logic [7:0]     restantes;
  logic           fim_de_jogo;

  always #5 clk = ~clk;

  fornecedor_de_comandos #(.N_LANES(N), .LIST_LEN(LL), .SEED(8'hA5)) dut (
    .CLOCK_25       (clk),
    .reset          (reset),
    .trocar         (trocar),
    .comando        (comando),
    .comando_valido (comando_valido),
    .restantes      (restantes),
    .fim_de_jogo    (fim_de_jogo)
  );

  typedef struct {
    int         lane;
    logic [3:0] cmd;
    logic [7:0] rest;
    logic       fim;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_lfsr;
  int         m_rest;
  logic       m_fim;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_reset();
    m_lfsr = 8'hA5;
    m_rest = LL;
    m_fim  = 1'b0;
    sb.delete();
  endtask

  task automatic push(input int lane);
    exp_t e;
    e.lane = lane;
    if (m_rest > 0) begin
      e.cmd  = 4'b0001 << m_lfsr[1:0];
      m_lfsr = model_next(m_lfsr);
      m_rest--;
      if (m_rest == 0) m_fim = 1'b1;
    end else begin
      e.cmd = 4'b0000;
    end
    e.rest = 8'(m_rest);
    e.fim  = m_fim;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (comando_valido !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(comando_valido), 32'd0);
      end else begin
        e = sb.pop_front();
        check("valid_lane", 32'(comando_valido), 32'(1 << e.lane));
        check("cmd", 32'(comando[4*e.lane +: 4]), 32'(e.cmd));
        check("restantes", 32'(restantes), 32'(e.rest));
        check("fim", 32'(fim_de_jogo), 32'(e.fim));
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    trocar = '0;
    model_reset();
    step();
    step();
    check("rst_comando", 32'(comando), 32'd0);
    check("rst_valid", 32'(comando_valido), 32'd0);
    check("rst_restantes", 32'(restantes), 32'd10);
    check("rst_fim", 32'(fim_de_jogo), 32'd0);
    reset = 1'b1;
    step();
    step();

    // Lone request: two-cycle latency, then held
    trocar = 3'b001;
    push(0);
    step();
    check("lat_no_early_valid", 32'(comando_valido), 32'd0);
    step();
    check("single_cmd", 32'(comando[3:0]), 32'b0010);
    check("single_rest", 32'(restantes), 32'd9);
    trocar = 3'b000;
    step();
    check("valid_one_cycle", 32'(comando_valido), 32'd0);
    for (int i = 0; i < 3; i++) begin
      trocar = 3'b001;
      push(0);
      step();
      step();
      trocar = 3'b000;
      step();
    end
    repeat (3) step();
    check("cmd_held", 32'(comando[3:0]), 32'b0100);
    check("drained_a", 32'(sb.size()), 32'd0);

    // Simultaneous requests after reset: 0,1,2 then 0 before 1
    reset = 1'b0;
    step();
    model_reset();
    check("rst_b_restantes", 32'(restantes), 32'd10);
    check("rst_b_comando", 32'(comando), 32'd0);
    reset = 1'b1;
    step();
    step();
    trocar = 3'b111;
    push(0); push(1); push(2);
    repeat (4) step();
    trocar = 3'b000;
    step();
    check("drained_b1", 32'(sb.size()), 32'd0);
    trocar = 3'b011;
    push(0); push(1);
    repeat (3) step();
    trocar = 3'b000;
    step();
    check("drained_b2", 32'(sb.size()), 32'd0);

    // Level held high gives a single request
    trocar = 3'b010;
    push(1);
    repeat (20) step();
    trocar = 3'b000;
    step();
    check("drained_c", 32'(sb.size()), 32'd0);

    // Reset with two requests pending, trocar held through release
    trocar = 3'b101;
    step();
    check("pre_reset_rest", 32'(restantes), 32'd4);
    reset = 1'b0;
    step();
    model_reset();
    check("mid_rst_comando", 32'(comando), 32'd0);
    check("mid_rst_valid", 32'(comando_valido), 32'd0);
    check("mid_rst_restantes", 32'(restantes), 32'd10);
    check("mid_rst_fim", 32'(fim_de_jogo), 32'd0);
    reset = 1'b1;
    repeat (5) step();
    check("no_grant_after_release", 32'(comando), 32'd0);
    trocar = 3'b000;
    step();

    // Second rise on lane 2 while still pending merges
    trocar = 3'b111;
    push(0); push(1); push(2);
    step();
    trocar = 3'b011;
    step();
    trocar = 3'b111;
    step();
    trocar = 3'b000;
    repeat (3) step();
    check("drained_d1", 32'(sb.size()), 32'd0);

    // Rise on lane 1 in its own grant cycle yields one more grant
    trocar = 3'b011;
    push(0); push(1); push(1);
    step();
    trocar = 3'b001;
    step();
    trocar = 3'b011;
    step();
    trocar = 3'b000;
    repeat (3) step();
    check("drained_d2", 32'(sb.size()), 32'd0);

    // Exhaust the list, then one grant past the end
    for (int i = 0; i < 4; i++) begin
      trocar = 3'(1 << (i % 3));
      push(i % 3);
      step();
      step();
      trocar = 3'b000;
      step();
    end
    check("end_fim", 32'(fim_de_jogo), 32'd1);
    check("end_rest", 32'(restantes), 32'd0);
    trocar = 3'b100;
    push(2);
    step();
    step();
    check("empty_cmd", 32'(comando[11:8]), 32'd0);
    trocar = 3'b000;
    step();
    check("rest_frozen", 32'(restantes), 32'd0);
    check("fim_sticky", 32'(fim_de_jogo), 32'd1);
    check("drained_e", 32'(sb.size()), 32'd0);

    reset = 1'b0;
    step();
    check("final_rst_fim", 32'(fim_de_jogo), 32'd0);
    check("final_rst_rest", 32'(restantes), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fornecedor_de_comandos.md
# fornecedor_de_comandos

Command supplier for the falling-pattern lanes: the responder end of the per-lane `trocar` request interface. Each pattern lane raises `trocar` when its sprite leaves the playfield and needs a new command. This block arbitrates those requests round-robin, then answers each one with a one-hot 4-bit command from an 8-bit LFSR plus a one-cycle valid strobe. It counts issued commands against the song length and raises `fim_de_jogo` when the list is exhausted. It sits in the top level between the `pattern` instances and the score/VGA logic, on the `CLOCK_25` domain.

## Interface
Parameters:
- `N_LANES`, 3, number of pattern lanes served (1–8)
- `LIST_LEN`, 10, commands per game (1–255)
- `SEED`, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01

Ports:
- `CLOCK_25`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `trocar`  in  N_LANES  per-lane request; rising edge = one request; level otherwise ignored
- `comando`  out  4*N_LANES  lane i command at bits [4i+3:4i]; held until that lane's next grant
- `comando_valido`  out  N_LANES  one-cycle strobe; bit i high in the cycle lane i's `comando` is updated
- `restantes`  out  8  commands still to issue (LIST_LEN down to 0)
- `fim_de_jogo`  out  1  sticky; high once LIST_LEN commands have been issued

## Operation
- Reset (`reset`=0 at a clock edge) sets:
  - `comando`=0, `comando_valido`=0, `fim_de_jogo`=0, `restantes`=LIST_LEN
  - pending=0, lfsr=SEED (01 if SEED=0), round-robin pointer=N_LANES-1
  - `trocar_prev` = all ones, so a level already high at reset release is not a request
- Edge detect: `rise[i] = trocar[i] & ~trocar_prev[i]`. `trocar_prev <= trocar` every cycle.
- Pending: `pending[i] <= (pending[i] & ~grant[i]) | rise[i]`.
  - A rise on a lane already pending merges into one request.
  - A rise in the same cycle that lane is granted re-sets pending, so it yields one further request.
- Arbiter:
  - At most one grant per cycle.
  - Winner is the first pending lane found searching from pointer+1 upward, mod N_LANES.
  - On a grant, pointer <= granted lane.
- Issue, for a grant to lane g while `restantes` > 0:
  - `comando[g] <= 4'b0001 << lfsr[1:0]`, using the pre-advance value.
  - lfsr advances.
  - `restantes` decrements.
  - `comando_valido[g]` pulses.
- LFSR: Fibonacci, `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`. It advances only on an issuing grant and is never zero.
- End of list:
  - `fim_de_jogo` rises on the same edge that `restantes` goes 1→0.
  - Later grants still occur and still pulse valid, but load `comando[g]`=4'b0000 (empty lane).
  - In that state lfsr and `restantes` are frozen.
  - `fim_de_jogo` stays high until reset.
- Reset mid-operation discards all pending requests and in-flight grants. No valid pulse occurs in the reset cycle.

## Timing
- Lone request: `trocar[i]` first sampled high at edge k sets pending at edge k. Grant happens at edge k+1, so `comando`/`comando_valido` are visible after edge k+1 (2-cycle latency).
- M simultaneous requests are served on M consecutive edges, in round-robin order.
- `comando_valido` is high for exactly one cycle per grant. It is never high on two lanes at once.
- All outputs are registered; there is no combinational path from `trocar` to any output.

## Test plan
- Reset then single request: SEED=A5, pulse `trocar[0]` → 2 cycles later, `comando[3:0]`=0010 with `comando_valido`=001 for one cycle, and `restantes`=9.
- Sequence check: four successive lane-0 requests → commands 0010, 0100, 0010, 0100 (lfsr A5→4A→95→2A→…). `comando` holds its value between requests.
- Simultaneous: `trocar`=111 rising in one cycle after reset → grants to lanes 0, 1, 2 on three consecutive cycles. Then lane 1 and lane 0 rise together → lane 0 served first (pointer=2).
- Merge/no-retrigger: `trocar[1]` held high 20 cycles → exactly one grant. A second rise while still pending → still one grant. A rise in the grant cycle → exactly two grants.
- End of list: LIST_LEN=10, issue 10 requests → `fim_de_jogo` rises with the 10th valid pulse and `restantes`=0. The 11th request → valid pulse with `comando`=0000, lfsr unchanged.
- Reset mid-game: assert `reset`=0 with two requests pending and `restantes`=4 → next cycle all outputs are at reset values, no stray valid pulse, `trocar` held high at release → no grant.
